// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Segment patterns are active-low, bit 6 = segment a, bit 0 = segment g.
package seg7_pkg;

  localparam int N_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [9:0][6:0] SEG_PAT = {
    7'b0001100,
    7'b0000000,
    7'b0001111,
    7'b0100000,
    7'b0100100,
    7'b1001100,
    7'b0000110,
    7'b0010010,
    7'b1001111,
    7'b0000001
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-decimal codes 10..15 produce an all-off pattern.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_PAT[bcd];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous reload.
// Define SEG7_LZ_SUPPRESS_EN to blank leading zeros on digits 3..1.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         digits_in,
  input  logic [N_DIGITS-1:0] dp_in,
  input  logic                load,
  output logic [N_DIGITS-1:0] an_n,
  output logic [0:6]          seg_n,
  output logic                dp_n,
  output logic                frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CYC);

  logic [CW-1:0]         cnt;
  logic [1:0]            idx;
  logic [15:0]           shadow_dg;
  logic [15:0]           active_dg;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [N_DIGITS-1:0]   active_dp;
  state_t                state;
  logic                  slot_end;
  logic                  frame_end;
  logic                  lz;
  logic [3:0]            cur;
  logic [0:6]            cur_seg;

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (idx == 2'd3);
  assign state     = (cnt < CNT_BLK) ? BLANK : DRIVE;
  assign cur       = active_dg[{idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd (cur),
    .seg (cur_seg)
  );

`ifdef SEG7_LZ_SUPPRESS_EN
  // Blank when this digit and every digit above it is zero.
  assign lz = (idx != 2'd0) &&
              ((active_dg >> {idx, 2'b00}) == 16'd0);
`else
  assign lz = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_dg  <= '0;
      shadow_dp  <= '0;
      active_dg  <= '0;
      active_dp  <= '0;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        shadow_dg <= digits_in;
        shadow_dp <= dp_in;
      end
      // Load coinciding with the boundary bypasses the shadow.
      if (frame_end) begin
        active_dg <= load ? digits_in : shadow_dg;
        active_dp <= load ? dp_in : shadow_dp;
      end
      frame_done <= frame_end;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      unique case (state)
        BLANK: begin
          an_n  <= '1;
          seg_n <= SEG_BLANK;
          dp_n  <= 1'b1;
        end
        DRIVE: begin
          an_n  <= ~(N_DIGITS'(1) << idx);
          seg_n <= lz ? SEG_BLANK : cur_seg;
          dp_n  <= ~active_dp[idx];
        end
      endcase
    end
  end

endmodule
